uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8: byte width.
REQ-002 SHALL have parameter DEPTH, default 16: entries; power of two, >= 4.
REQ-003 SHALL have parameter AFULL_LVL, default DEPTH-2: almost_full threshold.
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port wr_data  in  DATA_W  received byte from the upstream receiver.
REQ-007 SHALL have port wr_en  in  1  one-cycle write strobe; the receiver's receive_ack.
REQ-008 SHALL have port rd_data  out  DATA_W  oldest stored byte; valid while rd_valid is high.
REQ-009 SHALL have port rd_valid  out  1  FIFO non-empty.
REQ-010 SHALL have port rd_ready  in  1  downstream transmitter accepts rd_data.
REQ-011 SHALL have port count  out  log2(DEPTH)+1  stored entries, 0..DEPTH.
REQ-012 SHALL have ports full, empty, almost_full  out  1 each  occupancy flags.
REQ-013 SHALL have port overflow  out  1  sticky dropped-byte flag.
REQ-014 SHALL have port ovf_clear  in  1  one-cycle clear of overflow.

Function
REQ-015 SHALL store wr_data at wr_ptr on a clk edge with wr_en=1 and (full=0 or pop in the same cycle).
REQ-016 SHALL define pop as rd_valid=1 and rd_ready=1 in the same cycle; pop advances rd_ptr.
REQ-017 SHALL be first-word-fall-through: rd_data = mem[rd_ptr], read combinationally; a write into an empty FIFO at edge N gives rd_valid=1 after edge N.
REQ-018 SHALL NOT pop when empty, regardless of rd_ready; a write with rd_ready=1 into an empty FIFO is stored, not bypassed.
REQ-019 SHALL wrap wr_ptr and rd_ptr modulo DEPTH.
REQ-020 SHALL update count +1 on write only, -1 on pop only, and hold it on a simultaneous write and pop.
REQ-021 SHALL accept the write when full and a pop occur in the same cycle; count stays DEPTH.
REQ-022 SHALL drop the byte and set overflow on the next edge when wr_en=1, full=1 and there is no pop; contents and pointers stay unchanged.
REQ-023 SHALL hold overflow until ovf_clear=1; if a set and ovf_clear coincide, set wins.
REQ-024 SHALL register the flags from next-state count: empty=(count==0), full=(count==DEPTH), almost_full=(count>=AFULL_LVL), rd_valid=!empty.
REQ-025 SHALL keep rd_data stable while rd_valid=1 and rd_ready=0.
REQ-026 SHALL NOT require wr_en to be a single-cycle pulse; each high cycle is a separate write.

Reset
REQ-027 SHALL, while rst=1, set wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_full=0, rd_valid=0, overflow=0.
REQ-028 SHALL leave storage contents unreset; rd_data is don't-care while rd_valid=0.
REQ-029 SHALL discard all stored bytes and ignore wr_en and rd_ready when rst is asserted mid-operation.

Structure
REQ-030 SHALL take DATA_W, FIFO_DEPTH and the baud/divider constants shared by the UART stages from package uart_pkg.
REQ-031 SHALL place storage in one sub-module, uart_fifo_mem: DEPTH x DATA_W, synchronous write, asynchronous read.
REQ-032 SHALL keep pointers, count, flags and overflow logic in uart_rx_fifo.

Verification
REQ-033 SHALL test write-then-read: write 0x41 then 0x42 (rd_ready=0) -> count=2, rd_data=0x41; assert rd_ready for 2 cycles -> 0x41, 0x42 popped in order, then empty=1, rd_valid=0.
REQ-034 SHALL test fill and overflow: 16 writes 0x00..0x0F -> full=1, almost_full=1 from count 14; 17th write 0xFF -> overflow=1, count=16; drain yields 0x00..0x0F with 0xFF absent.
REQ-035 SHALL test simultaneous events: full with wr_en=1 and rd_ready=1 (write 0xA5) -> count stays 16, overflow=0, 0xA5 read last; empty with wr_en=1 and rd_ready=1 -> count=1, nothing popped.
REQ-036 SHALL test wrap: 40 interleaved write/pop pairs with incrementing data -> output sequence identical to input, count never exceeds 1.
REQ-037 SHALL test reset mid-operation: count=5 with overflow=1, pulse rst -> count=0, empty=1, overflow=0; next write 0x33 is the first byte read.
REQ-038 SHALL test overflow clear: ovf_clear coincident with an overflow event -> overflow stays 1; ovf_clear alone next cycle -> overflow=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Constants shared by the UART receive path: byte width, FIFO depth and baud divider.
package uart_pkg;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int CLK_HZ     = 50_000_000;
  localparam int BAUD       = 115_200;
  localparam int OVERSAMPLE = 16;
  localparam int BAUD_DIV   = CLK_HZ / (BAUD * OVERSAMPLE);

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage array: synchronous write port, asynchronous read port.
module uart_fifo_mem #(
  parameter  int DATA_W = uart_pkg::DATA_W,
  parameter  int DEPTH  = uart_pkg::FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: storage carries no reset; the occupancy logic in the parent never exposes stale entries.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO between the UART receiver and its consumer,
// with registered occupancy flags and a sticky overflow indicator.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_W    = uart_pkg::DATA_W,
  parameter  int DEPTH     = uart_pkg::FIFO_DEPTH,
  parameter  int AFULL_LVL = DEPTH - 2,
  localparam int PTR_W     = ptr_w(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              overflow,
  input  logic              ovf_clear
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             afull_q, afull_d;
  logic             ovf_q, ovf_d;
  logic             push, pop, ovf_set;

  // NOTE: every signal written here is assigned on every path, so no latch can be inferred.
  always_comb begin
    pop      = ~empty_q & rd_ready;
    push     = wr_en & (~full_q | pop);
    ovf_set  = wr_en & full_q & ~pop;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    empty_d  = (count_d == '0);
    full_d   = (count_d == CNT_W'(DEPTH));
    afull_d  = (count_d >= CNT_W'(AFULL_LVL));
    ovf_d    = ovf_set | (ovf_q & ~ovf_clear);
  end

  // NOTE: state flops use non-blocking assignment so all of them update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
    end
  end

  // Writes are suppressed during reset so a held wr_en cannot touch storage.
  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk    (clk),
    .we     (push & ~rst),
    .waddr  (wr_ptr_q),
    .wdata  (wr_data),
    .raddr  (rd_ptr_q),
    .rdata  (rd_data)
  );

  assign rd_valid    = ~empty_q;
  assign count       = count_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign overflow    = ovf_q;

endmodule
